// File: rtl/pipe_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : Processor_Pkg
// Description : Shared types and constants for the pipeline control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package Processor_Pkg;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_FLUSH     = 2'b01,
        ST_WAIT_INST = 2'b10
    } ctrl_state_t;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_EXC = 3'b010;

    localparam int STG_IF    = 0;
    localparam int STG_IF_ID = 1;
    localparam int STG_ID_RN = 2;
    localparam int STG_RN_IS = 3;
    localparam int STG_IS    = 4;
    localparam int STG_EX0   = 5;

    // Wide enough for the largest legal flush hold (15 cycles).
    localparam int HOLD_W = 4;

endpackage : Processor_Pkg
`default_nettype wire

// File: rtl/pipe_ctrl_unit_br_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : br_prio_enc
// Description : Priority encoder selecting the oldest (lowest) branch channel.
// Revision    : 1.0 - initial release
// ============================================================================
module br_prio_enc #(
    parameter int NUM_BR = 2
) (
    input  logic [NUM_BR-1:0]         i_req,
    output logic                      o_valid,
    output logic [$clog2(NUM_BR):0]   o_idx
);
    localparam int IDX_W = $clog2(NUM_BR) + 1;

    assign o_valid = |i_req;

    // Scanning downward lets the lowest set index overwrite younger ones.
    always_comb begin
        o_idx = '0;
        for (int i = NUM_BR - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule : br_prio_enc
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : Pipeline stall/flush sequencer with redirect selection and
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit
    import Processor_Pkg::*;
#(
    parameter int NUM_STAGES   = 6,
    parameter int NUM_BR       = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rob_full,
    input  logic                          rename_fail,
    input  logic                          inst_ready,
    input  logic [NUM_BR-1:0]             br_occur,
    input  logic                          exc_occur,
    input  logic                          commit,
    output logic                          inst_req,
    output logic [2:0]                    pcsrc_sel,
    output logic [$clog2(NUM_BR):0]       br_sel,
    output stage_ctrl_t [NUM_STAGES-1:0]  stage_ctrl,
    output logic                          branch_flush,
    output logic [1:0]                    ctrl_state,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);
    localparam int                BSW        = $clog2(NUM_BR) + 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(FLUSH_CYCLES - 1);
    // A single-cycle hold is fully covered by the event cycle itself.
    localparam ctrl_state_t       LOAD_STATE = (FLUSH_CYCLES == 1) ? ST_WAIT_INST : ST_FLUSH;

    ctrl_state_t         r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic                w_hazard;
    logic                w_exc;
    logic                w_br_any;
    logic                w_event;
    logic                w_accept;
    logic [BSW-1:0]      w_br_idx;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_flush;

    br_prio_enc #(
        .NUM_BR (NUM_BR)
    ) u_br_prio_enc (
        .i_req   (br_occur),
        .o_valid (w_br_any),
        .o_idx   (w_br_idx)
    );

    assign w_hazard = rob_full | rename_fail;
    assign w_exc    = exc_occur & commit;
    assign w_event  = w_exc | w_br_any;
    // Branches seen during a flush are on the wrong path and never count.
    assign w_accept = !rst && ((r_state == ST_FLUSH) ? w_exc : w_event);

    always_comb begin
        inst_req     = 1'b0;
        pcsrc_sel    = PCSRC_SEQ;
        br_sel       = '0;
        branch_flush = 1'b0;
        w_stall      = '0;
        w_flush      = '0;
        if (rst) begin
            w_flush = '1;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    w_flush      = '1;
                    branch_flush = 1'b1;
                    if (w_exc) begin
                        pcsrc_sel = PCSRC_EXC;
                    end
                end
                ST_WAIT_INST: begin
                    inst_req         = 1'b1;
                    w_stall[STG_IF]  = !inst_ready;
                end
                default: begin
                    inst_req            = !w_hazard;
                    w_stall[STG_IF]     = w_hazard | !inst_ready;
                    w_stall[STG_IF_ID]  = w_hazard;
                    w_stall[STG_ID_RN]  = w_hazard;
                    w_stall[STG_RN_IS]  = rob_full;
                    w_stall[STG_IS]     = rob_full;
                    w_flush[STG_RN_IS]  = rename_fail & !rob_full;
                end
            endcase
            if (r_state != ST_FLUSH && w_event) begin
                w_flush      = '1;
                branch_flush = 1'b1;
                if (w_exc) begin
                    pcsrc_sel = PCSRC_EXC;
                end else begin
                    pcsrc_sel = PCSRC_BR;
                    br_sel    = w_br_idx;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        assign stage_ctrl[g].flush = w_flush[g];
        assign stage_ctrl[g].stall = w_stall[g] & ~w_flush[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_hold      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state == ST_RUN && w_hazard && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_accept && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (r_state == ST_FLUSH) begin
                if (w_exc) begin
                    r_state <= LOAD_STATE;
                    r_hold  <= HOLD_INIT;
                end else if (r_hold <= HOLD_W'(1)) begin
                    r_state <= ST_WAIT_INST;
                    r_hold  <= '0;
                end else begin
                    r_hold  <= r_hold - HOLD_W'(1);
                end
            end else if (w_event) begin
                r_state <= LOAD_STATE;
                r_hold  <= HOLD_INIT;
            end else if (r_state == ST_WAIT_INST) begin
                if (inst_ready) begin
                    r_state <= ST_RUN;
                end
            end else begin
                r_state <= ST_RUN;
            end
        end
    end

    assign ctrl_state = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule : pipe_ctrl_unit
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_unit
// Description : Scoreboard bench for pipe_ctrl_unit (default params plus a
//               CNT_W=4 instance sharing the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;
    import Processor_Pkg::*;

    localparam logic [1:0] S_R = 2'b00;
    localparam logic [1:0] S_F = 2'b01;
    localparam logic [1:0] S_W = 2'b10;

    typedef struct packed {
        logic       r;
        logic       rf;
        logic       rn;
        logic       ir;
        logic [1:0] br;
        logic       ex;
        logic       cm;
    } stim_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [2:0]  pc;
        logic [1:0]  bs;
        logic        bf;
        logic        iq;
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  sc4;
    } obs_t;

    logic clk, rst, rob_full, rename_fail, inst_ready, exc_occur, commit;
    logic [1:0] br_occur;
    logic inst_req, branch_flush, inst_req4, branch_flush4;
    logic [2:0] pcsrc_sel, pcsrc_sel4;
    logic [1:0] br_sel, br_sel4, ctrl_state, ctrl_state4;
    stage_ctrl_t [5:0] stage_ctrl, stage_ctrl4;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_run  = 0;
    int n_fail = 0;
    int e_sc   = 0;
    int e_fc   = 0;
    int e_sc4  = 0;
    stim_t sq[$];
    obs_t  sb[$];

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .rob_full(rob_full), .rename_fail(rename_fail),
        .inst_ready(inst_ready), .br_occur(br_occur), .exc_occur(exc_occur),
        .commit(commit), .inst_req(inst_req), .pcsrc_sel(pcsrc_sel),
        .br_sel(br_sel), .stage_ctrl(stage_ctrl), .branch_flush(branch_flush),
        .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rob_full(rob_full), .rename_fail(rename_fail),
        .inst_ready(inst_ready), .br_occur(br_occur), .exc_occur(exc_occur),
        .commit(commit), .inst_req(inst_req4), .pcsrc_sel(pcsrc_sel4),
        .br_sel(br_sel4), .stage_ctrl(stage_ctrl4), .branch_flush(branch_flush4),
        .ctrl_state(ctrl_state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.st = ctrl_state; o.pc = pcsrc_sel; o.bs = br_sel;
        o.bf = branch_flush; o.iq = inst_req;
        for (int i = 0; i < 6; i++) begin
            o.stall[i] = stage_ctrl[i].stall;
            o.flush[i] = stage_ctrl[i].flush;
        end
        o.sc = stall_cnt; o.fc = flush_cnt; o.sc4 = stall_cnt4;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%b pc=%b bs=%0d bf=%b iq=%b stall=%b flush=%b sc=%0d fc=%0d sc4=%0d",
                         o.st, o.pc, o.bs, o.bf, o.iq, o.stall, o.flush, o.sc, o.fc, o.sc4);
    endfunction

    // Queue one cycle of stimulus with its expected outputs; counters come
    // from the bench's running model of the counting rules.
    task automatic add(input logic r, rf, rn, ir, input logic [1:0] br, input logic ex, cm,
                       input logic [1:0] st, input logic [2:0] pc, input logic [1:0] bs,
                       input logic bf, iq, input logic [5:0] stl, fl);
        stim_t s;
        obs_t  e;
        logic  ev;
        s = '{r: r, rf: rf, rn: rn, ir: ir, br: br, ex: ex, cm: cm};
        e = '{st: st, pc: pc, bs: bs, bf: bf, iq: iq, stall: stl, flush: fl,
              sc: 16'(e_sc), fc: 16'(e_fc), sc4: 4'(e_sc4)};
        sq.push_back(s);
        sb.push_back(e);
        if (r) begin
            e_sc = 0; e_fc = 0; e_sc4 = 0;
        end else begin
            if (st == S_R && (rf | rn)) begin
                if (e_sc < 65535) e_sc++;
                if (e_sc4 < 15) e_sc4++;
            end
            ev = (st == S_F) ? (ex & cm) : ((ex & cm) | (|br));
            if (ev && e_fc < 65535) e_fc++;
        end
    endtask

    task automatic drive(input stim_t s);
        rst = s.r; rob_full = s.rf; rename_fail = s.rn; inst_ready = s.ir;
        br_occur = s.br; exc_occur = s.ex; commit = s.cm;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        int k = 0;
        add(1,0,0,1,2'b11,1,1, S_R,3'b000,2'd0,0,0,6'h00,6'h3f);
        add(1,1,1,0,2'b00,0,0, S_R,3'b000,2'd0,0,0,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        add(0,0,0,0,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h01,6'h00);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clk);
            exp = sb.pop_front(); got = observe(); n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset step%0d: got %s | expected %s", k, fmt(got), fmt(exp));
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        obs_t got, exp;
        int k = 0;
        add(0,0,0,1,2'b11,0,0, S_R,3'b001,2'd0,1,1,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_F,3'b000,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,0,2'b00,0,0, S_W,3'b000,2'd0,0,1,6'h01,6'h00);
        add(0,0,0,1,2'b00,0,0, S_W,3'b000,2'd0,0,1,6'h00,6'h00);
        add(0,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clk);
            exp = sb.pop_front(); got = observe(); n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL branch step%0d: got %s | expected %s", k, fmt(got), fmt(exp));
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exc_priority();
        obs_t got, exp;
        int k = 0;
        add(0,0,0,1,2'b00,1,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        add(0,0,0,1,2'b01,1,1, S_R,3'b010,2'd0,1,1,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_F,3'b000,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_W,3'b000,2'd0,0,1,6'h00,6'h00);
        add(0,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clk);
            exp = sb.pop_front(); got = observe(); n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL exc_priority step%0d: got %s | expected %s", k, fmt(got), fmt(exp));
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_events();
        obs_t got, exp;
        int k = 0;
        add(0,0,0,1,2'b01,0,0, S_R,3'b001,2'd0,1,1,6'h00,6'h3f);
        add(0,0,0,1,2'b00,1,1, S_F,3'b010,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,1,2'b10,0,0, S_F,3'b000,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_W,3'b000,2'd0,0,1,6'h00,6'h00);
        add(0,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clk);
            exp = sb.pop_front(); got = observe(); n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flush_events step%0d: got %s | expected %s", k, fmt(got), fmt(exp));
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        int k = 0;
        add(0,0,0,1,2'b10,0,0, S_R,3'b001,2'd1,1,1,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_F,3'b000,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,0,2'b01,0,0, S_W,3'b001,2'd0,1,1,6'h00,6'h3f);
        add(0,0,0,1,2'b00,1,1, S_F,3'b010,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_F,3'b000,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_W,3'b000,2'd0,0,1,6'h00,6'h00);
        add(0,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clk);
            exp = sb.pop_front(); got = observe(); n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back step%0d: got %s | expected %s", k, fmt(got), fmt(exp));
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_run_stalls();
        obs_t got, exp;
        int k = 0;
        for (int i = 0; i < 3; i++)
            add(0,0,1,1,2'b00,0,0, S_R,3'b000,2'd0,0,0,6'b000111,6'b001000);
        add(0,1,1,1,2'b00,0,0, S_R,3'b000,2'd0,0,0,6'b011111,6'h00);
        add(0,1,0,0,2'b00,0,0, S_R,3'b000,2'd0,0,0,6'b011111,6'h00);
        add(0,0,0,0,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'b000001,6'h00);
        add(0,1,0,1,2'b01,0,0, S_R,3'b001,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_F,3'b000,2'd0,1,0,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_W,3'b000,2'd0,0,1,6'h00,6'h00);
        add(0,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clk);
            exp = sb.pop_front(); got = observe(); n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL run_stalls step%0d: got %s | expected %s", k, fmt(got), fmt(exp));
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        obs_t got, exp;
        int k = 0;
        add(1,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,0,6'h00,6'h3f);
        for (int i = 0; i < 20; i++)
            add(0,1,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,0,6'b011111,6'h00);
        add(0,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clk);
            exp = sb.pop_front(); got = observe(); n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL saturation step%0d: got %s | expected %s", k, fmt(got), fmt(exp));
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_flush();
        obs_t got, exp;
        int k = 0;
        add(0,0,0,1,2'b01,0,0, S_R,3'b001,2'd0,1,1,6'h00,6'h3f);
        add(1,0,0,1,2'b00,1,1, S_F,3'b000,2'd0,0,0,6'h00,6'h3f);
        add(1,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,0,6'h00,6'h3f);
        add(0,0,0,1,2'b00,0,0, S_R,3'b000,2'd0,0,1,6'h00,6'h00);
        while (sq.size() != 0) begin
            drive(sq.pop_front());
            @(negedge clk);
            exp = sb.pop_front(); got = observe(); n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_flush step%0d: got %s | expected %s", k, fmt(got), fmt(exp));
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; rob_full = 1'b0; rename_fail = 1'b0; inst_ready = 1'b1;
        br_occur = 2'b00; exc_occur = 1'b0; commit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_branch();
        test_exc_priority();
        test_flush_events();
        test_back_to_back();
        test_run_stalls();
        test_saturation();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_pipe_ctrl_unit
`default_nettype wire
